// File: rtl/array_check_arbiter_if.sv
// Bus between the requester-side clients, the array_check_arbiter and the
// shared sort-check unit. The arbiter connects through the master modport;
// clients and the checker (or a testbench) drive the slave side.
interface array_check_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 32
);
  // Requester side
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic [NUM_REQ*LEN_W-1:0]  req_length;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_sorted;
  logic                      resp_timeout;
  logic                      busy;
  // Checker side
  logic                      chk_go;
  logic [ADDR_W-1:0]         chk_base;
  logic [LEN_W-1:0]          chk_length;
  logic                      chk_done;
  logic                      chk_sorted;

  modport master (
    input  req, req_base, req_length, chk_done, chk_sorted,
    output gnt, resp_valid, resp_sorted, resp_timeout, busy,
           chk_go, chk_base, chk_length
  );

  modport slave (
    output req, req_base, req_length, chk_done, chk_sorted,
    input  gnt, resp_valid, resp_sorted, resp_timeout, busy,
           chk_go, chk_base, chk_length
  );
endinterface

// File: rtl/array_check_arbiter.sv
// array_check_arbiter: shares one array sort-check unit among NUM_REQ
// requesters. Round-robin pick in IDLE, latch the winner's base/length,
// pulse chk_go, skip one settle cycle (done may still be high from the
// previous job), wait for a fresh chk_done and return the verdict as a
// one-cycle resp_valid pulse to the winner.
// Optional feature: define ARRAY_ARB_TIMEOUT_EN to enable a watchdog that
// forces a response with resp_timeout=1 after TIMEOUT cycles without done.
module array_check_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  array_check_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("array_check_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_GO, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr;        // last granted requester
  logic [IDX_W-1:0]   idx;        // requester owning the current job
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   scan_k;
  logic               pick_valid;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   length_q;
  logic               verdict_q;
  logic               wait_expired;
  logic [NUM_REQ-1:0] idx_onehot;

  // Round-robin pick: first requester set, scanning upward from ptr+1.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    pick       = '0;
    pick_valid = 1'b0;
    scan_k     = '0;
    // Descending offset: the last hit written is the closest to ptr+1.
    for (int off = NUM_REQ; off >= 1; off--) begin
      scan_k = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (bus.req[scan_k]) begin
        pick       = scan_k;
        pick_valid = 1'b1;
      end
    end
  end

`ifdef ARRAY_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_q;

  assign wait_expired = (wait_cnt + 32'd1) >= 32'(TIMEOUT);

  // Watchdog: count cycles since GO, flag a forced response if done never comes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_GO: begin
          wait_cnt  <= '0;
          timeout_q <= 1'b0;
        end
        S_SETTLE: wait_cnt <= wait_cnt + 32'd1;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          // A done arriving on the limit cycle wins over the watchdog.
          if (!bus.chk_done && wait_expired) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_timeout = (state == S_RESP) && timeout_q;
`else
  assign wait_expired     = 1'b0;
  assign bus.resp_timeout = 1'b0;
`endif

  // State register plus the job context captured at grant and at done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      idx       <= '0;
      base_q    <= '0;
      length_q  <= '0;
      verdict_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state <= state_next;
      if (state == S_IDLE && pick_valid) begin
        idx      <= pick;
        ptr      <= pick;
        base_q   <= bus.req_base[int'(pick)*ADDR_W +: ADDR_W];
        length_q <= bus.req_length[int'(pick)*LEN_W +: LEN_W];
      end
      if (state == S_WAIT) begin
        if (bus.chk_done)      verdict_q <= bus.chk_sorted;
        else if (wait_expired) verdict_q <= 1'b0;
      end
    end
  end

  // Next-state: IDLE -> GO -> SETTLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (pick_valid) state_next = S_GO;
      S_GO:     state_next = S_SETTLE;
      S_SETTLE: state_next = S_WAIT;   // chk_done may be stale here
      S_WAIT:   if (bus.chk_done || wait_expired) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign idx_onehot = NUM_REQ'(1) << idx;

  // Outputs decode from state so reset clears them in the same cycle.
  assign bus.busy        = (state != S_IDLE);
  assign bus.gnt         = (state != S_IDLE) ? idx_onehot : '0;
  assign bus.resp_valid  = (state == S_RESP) ? idx_onehot : '0;
  assign bus.resp_sorted = (state == S_RESP) && verdict_q;
  assign bus.chk_go      = (state == S_GO);
  assign bus.chk_base    = base_q;
  assign bus.chk_length  = length_q;

endmodule
